// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add unsigned multiplier with valid/ready handshakes on both sides.
// Optional build macro ZERO_SKIP_EN enables early termination on zero operands and leading-zero multiplier bits.
module mult_seq_ctrl #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [W-1:0]   x_r;
  logic [W-1:0]   y_r;
  logic [2*W-1:0] acc;
  logic [KW-1:0]  k;
  logic           idle_r;

  logic [2*W-1:0] pp_row;
  logic           last_bit;
  logic           zero_op;

  assign pp_row = {{W{1'b0}}, x_r} << k;

`ifdef ZERO_SKIP_EN
  // Stop once no set bits remain above the one being processed.
  assign last_bit = (k == K_LAST) || (((y_r >> k) >> 1) == '0);
  assign zero_op  = (x == '0) || (y == '0);
`else
  assign last_bit = (k == K_LAST);
  assign zero_op  = 1'b0;
`endif

  // Gated by rst_n so in_ready reads low while reset is held and high right after release.
  assign in_ready = idle_r & rst_n;
  assign product  = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_r       <= '0;
      y_r       <= '0;
      acc       <= '0;
      k         <= '0;
      idle_r    <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r    <= x;
            y_r    <= y;
            acc    <= '0;
            k      <= '0;
            idle_r <= 1'b0;
            busy   <= 1'b1;
            if (zero_op) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          // Accumulator enable follows the multiplier bit so zero rows never toggle acc.
          if (y_r[k]) acc <= acc + pp_row;
          k <= k + 1'b1;
          if (last_bit) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            idle_r    <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          idle_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed cases plus a randomized scoreboard run.
module tb_mult_seq_ctrl;

  localparam int W = 8;
  localparam int NPAIRS = 2000;
`ifdef ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  localparam logic [7:0] DX [5] = '{8'hFF, 8'h35, 8'h00, 8'h80, 8'h01};
  localparam logic [7:0] DY [5] = '{8'hFF, 8'h01, 8'hA5, 8'h80, 8'h00};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] product;
  logic          busy;

  int checks = 0;
  int errors = 0;

  mult_seq_ctrl #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  // Edges from acceptance (inclusive) until out_valid is visible.
  function automatic int exp_lat(logic [7:0] a, logic [7:0] b);
    if (ZS && (a == 8'd0 || b == 8'd0)) return 1;
    if (ZS) return $clog2(int'(b) + 1) + 1;
    return W + 1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (product !== 16'h0) begin errors++; $display("FAIL reset_product: got %h expected 0000", product); end
    #2 rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: in_ready=%b busy=%b expected 1/0", in_ready, busy); end
  endtask

  task automatic test_directed();
    int lat;
    logic [15:0] exp_p;
    for (int i = 0; i < 5; i++) begin
      exp_p = 16'(DX[i]) * 16'(DY[i]);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_ready: got %b expected 1", i, in_ready); end
      x = DX[i]; y = DY[i]; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; x = 8'($urandom); y = 8'($urandom);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL dir%0d_busy: busy=%b in_ready=%b expected 1/0", i, busy, in_ready); end
        if (DX[i] == 8'h00) begin
          checks++; if (product !== 16'h0) begin errors++; $display("FAIL dir%0d_acc_idle: got %h expected 0000", i, product); end
        end
        @(negedge clk); lat++;
      end
      checks++; if (lat != exp_lat(DX[i], DY[i])) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, exp_lat(DX[i], DY[i])); end
      checks++; if (product !== exp_p) begin errors++; $display("FAIL dir%0d_product: got %h expected %h", i, product, exp_p); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_release: out_valid=%b in_ready=%b expected 0/1", i, out_valid, in_ready); end
      checks++; if (product !== exp_p) begin errors++; $display("FAIL dir%0d_retain: got %h expected %h", i, product, exp_p); end
    end
  endtask

  task automatic test_hold();
    int lat;
    @(negedge clk);
    x = 8'h12; y = 8'h34; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk); lat++;
      x = 8'($urandom); y = 8'($urandom); in_valid = 1'($urandom_range(0, 1));
    end
    checks++; if (lat != exp_lat(8'h12, 8'h34)) begin errors++; $display("FAIL hold_latency: got %0d expected %0d", lat, exp_lat(8'h12, 8'h34)); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      checks++; if (out_valid !== 1'b1 || product !== 16'h03A8 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_cycle%0d: out_valid=%b product=%h in_ready=%b expected 1/03a8/0", c, out_valid, product, in_ready);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h03A8) begin
      errors++; $display("FAIL hold_release: in_ready=%b out_valid=%b product=%h expected 1/0/03a8", in_ready, out_valid, product);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    x = 8'hC3; y = 8'h7E; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL abort_pre: busy=%b out_valid=%b expected 1/0", busy, out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'h0) begin
      errors++; $display("FAIL abort_reset: in_ready=%b out_valid=%b busy=%b product=%h expected 0/0/0/0000", in_ready, out_valid, busy, product);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_valid: got %b expected 0", out_valid); end
    #2 rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    x = 8'h02; y = 8'h03; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    checks++; if (out_valid !== 1'b1 || product !== 16'h0006) begin errors++; $display("FAIL abort_next: out_valid=%b product=%h expected 1/0006", out_valid, product); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] exp_q[$];
    int lat_q[$];
    int cyc_q[$];
    int cyc = 0;
    int n_acc = 0;
    int n_done = 0;
    bit ov_prev = 1'b0;
    while ((n_acc < NPAIRS || exp_q.size() != 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL rand_spurious: out_valid=1 product=%h expected no output", product);
        end else begin
          if (!ov_prev) begin
            checks++; if (cyc - cyc_q[0] != lat_q[0]) begin errors++; $display("FAIL rand_latency: got %0d expected %0d", cyc - cyc_q[0], lat_q[0]); end
          end
          checks++; if (product !== exp_q[0]) begin errors++; $display("FAIL rand_product: got %h expected %h", product, exp_q[0]); end
        end
      end
      ov_prev = (out_valid === 1'b1);
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid === 1'b1 && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front()); void'(lat_q.pop_front()); void'(cyc_q.pop_front());
        n_done++;
      end
      x = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      y = ($urandom_range(0, 3) == 0) ? 8'(8'h01 << $urandom_range(0, 7)) : 8'($urandom);
      in_valid = (n_acc < NPAIRS) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(16'(x) * 16'(y));
        lat_q.push_back(exp_lat(x, y));
        cyc_q.push_back(cyc);
        n_acc++;
      end
    end
    in_valid = 1'b0;
    checks++; if (n_done != NPAIRS || n_acc != NPAIRS) begin errors++; $display("FAIL rand_count: accepted=%0d completed=%0d expected %0d", n_acc, n_done, NPAIRS); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
